// File: rtl/pipe_reg_stage.sv
// Parametrised valid/ready register pipeline with bubble collapse, flush and occupancy count.
// Each stage advances whenever the stage downstream of it is empty or is itself advancing.
module pipe_reg_stage #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter bit               FLUSH_DATA = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] rdy;
    logic [CW-1:0]    count_q;
    logic             accept;
    logic             consume;

    // Ready ripples back from the output: a stage can load if it is empty or its
    // downstream neighbour can load. Walking downward keeps each bit written before read.
    // NOTE: always_comb gives rdy a full default first so no path leaves it unassigned (no latch).
    always_comb begin
        rdy          = '0;
        rdy[DEPTH-1] = out_ready | ~vld_q[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            rdy[i] = rdy[i+1] | ~vld_q[i];
        end
    end

    assign in_ready  = rdy[0] & ~flush & rst;
    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign count     = count_q;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    // Valid bits and occupancy; reset wins over flush, flush wins over any transfer.
    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            vld_q   <= '0;
            count_q <= '0;
        end else begin
            if (rdy[0]) vld_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) vld_q[i] <= vld_q[i-1];
            end
            if (accept && !consume)      count_q <= count_q + CW'(1);
            else if (consume && !accept) count_q <= count_q - CW'(1);
        end
    end

    // Data only moves with a valid word, so empty stages never toggle.
    // NOTE: the data array is a set of flops, not RAM, so resetting it to RESET_VAL is legal and cheap.
    always_ff @(posedge clk) begin
        if (!rst || (flush && FLUSH_DATA)) begin
            for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VAL;
        end else if (!flush) begin
            if (rdy[0] && in_valid) data_q[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i] && vld_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end
endmodule
